// File: rtl/game_pkg.sv
// Shared game-flow types and constants for the score controller.
package game_pkg;

    // Encoded game phase; the numeric values are exported to display logic.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4
    } game_state_t;

    localparam logic [1:0] WINNER_NONE  = 2'b00;
    localparam logic [1:0] WINNER_LEFT  = 2'b01;
    localparam logic [1:0] WINNER_RIGHT = 2'b10;

    localparam int unsigned DEF_WIN_SCORE   = 9;
    localparam int unsigned DEF_SCORE_W     = 4;
    localparam int unsigned DEF_SERVE_TICKS = 60;
    localparam int unsigned DEF_POINT_TICKS = 30;
    localparam int unsigned DEF_CNT_W       = 7;

endpackage

// File: rtl/tick_timer.sv
// Phase countdown: load sets the count, each tick decrements until zero.
module tick_timer #(
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             zero
);

    logic [CNT_W-1:0] r_cnt;

    // Load wins over tick; the count saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/score_controller.sv
// Game-flow FSM and scorekeeper: gates ball motion and tracks both scores.
module score_controller
    import game_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = DEF_WIN_SCORE,
    parameter int unsigned SCORE_W     = DEF_SCORE_W,
    parameter int unsigned SERVE_TICKS = DEF_SERVE_TICKS,
    parameter int unsigned POINT_TICKS = DEF_POINT_TICKS,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               timing_tick,
    input  logic               miss_left,
    input  logic               miss_right,
    input  logic               start,
    output logic               ball_enable,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic [2:0]         game_state,
    output logic               game_over,
    output logic [1:0]         winner
);

    localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_TICKS - 1);
    localparam logic [CNT_W-1:0]   POINT_LOAD = CNT_W'(POINT_TICKS - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    game_state_t        r_state, w_state_d;
    logic [SCORE_W-1:0] r_score_l, w_score_l_d;
    logic [SCORE_W-1:0] r_score_r, w_score_r_d;
    logic [1:0]         r_winner, w_winner_d;
    logic               r_ball_enable, r_game_over, r_start_q;
    logic               w_start_rise, w_tmr_load, w_tmr_tick, w_tmr_zero;
    logic [CNT_W-1:0]   w_tmr_load_val;
    logic [SCORE_W-1:0] w_inc_l, w_inc_r;

    assign w_start_rise = start & ~r_start_q;
    assign w_inc_l      = r_score_l + SCORE_W'(1);
    assign w_inc_r      = r_score_r + SCORE_W'(1);
    // Only the countdown phases consume ticks.
    assign w_tmr_tick   = timing_tick & ((r_state == SERVE) | (r_state == POINT));

    tick_timer #(
        .CNT_W (CNT_W)
    ) u_tick_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_tmr_load),
        .load_val (w_tmr_load_val),
        .tick     (w_tmr_tick),
        .zero     (w_tmr_zero)
    );

    // Next-state, score and timer-load decode.
    always_comb begin
        w_state_d      = r_state;
        w_score_l_d    = r_score_l;
        w_score_r_d    = r_score_r;
        w_winner_d     = r_winner;
        w_tmr_load     = 1'b0;
        w_tmr_load_val = SERVE_LOAD;
        unique case (r_state)
            IDLE: begin
                if (w_start_rise) begin
                    w_state_d  = SERVE;
                    w_tmr_load = 1'b1;
                end
            end
            SERVE: begin
                if (timing_tick && w_tmr_zero) begin
                    w_state_d = PLAY;
                end
            end
            PLAY: begin
                if (timing_tick) begin
                    if (miss_left && miss_right) begin
                        // Simultaneous misses: no point, straight to a fresh serve.
                        w_state_d  = SERVE;
                        w_tmr_load = 1'b1;
                    end else if (miss_left) begin
                        w_score_r_d = w_inc_r;
                        if (w_inc_r == WIN_VAL) begin
                            w_state_d  = GAME_OVER;
                            w_winner_d = WINNER_RIGHT;
                        end else begin
                            w_state_d      = POINT;
                            w_tmr_load     = 1'b1;
                            w_tmr_load_val = POINT_LOAD;
                        end
                    end else if (miss_right) begin
                        w_score_l_d = w_inc_l;
                        if (w_inc_l == WIN_VAL) begin
                            w_state_d  = GAME_OVER;
                            w_winner_d = WINNER_LEFT;
                        end else begin
                            w_state_d      = POINT;
                            w_tmr_load     = 1'b1;
                            w_tmr_load_val = POINT_LOAD;
                        end
                    end
                end
            end
            POINT: begin
                if (timing_tick && w_tmr_zero) begin
                    w_state_d  = SERVE;
                    w_tmr_load = 1'b1;
                end
            end
            GAME_OVER: begin
                if (w_start_rise) begin
                    w_state_d   = SERVE;
                    w_score_l_d = '0;
                    w_score_r_d = '0;
                    w_winner_d  = WINNER_NONE;
                    w_tmr_load  = 1'b1;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // State, scores and registered outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_score_l     <= '0;
            r_score_r     <= '0;
            r_winner      <= WINNER_NONE;
            r_ball_enable <= 1'b0;
            r_game_over   <= 1'b0;
            r_start_q     <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_score_l     <= w_score_l_d;
            r_score_r     <= w_score_r_d;
            r_winner      <= w_winner_d;
            r_ball_enable <= (w_state_d == PLAY);
            r_game_over   <= (w_state_d == GAME_OVER);
            r_start_q     <= start;
        end
    end

    assign ball_enable = r_ball_enable;
    assign score_left  = r_score_l;
    assign score_right = r_score_r;
    assign game_state  = r_state;
    assign game_over   = r_game_over;
    assign winner      = r_winner;

endmodule

// File: tb/tb_score_controller.sv
// Directed self-checking bench for score_controller.
module tb_score_controller;

    logic       clk;
    logic       rst_n;
    logic       timing_tick;
    logic       miss_left;
    logic       miss_right;
    logic       start;
    logic       ball_enable;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic [2:0] game_state;
    logic       game_over;
    logic [1:0] winner;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_POINT = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    score_controller u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .timing_tick (timing_tick),
        .miss_left   (miss_left),
        .miss_right  (miss_right),
        .start       (start),
        .ball_enable (ball_enable),
        .score_left  (score_left),
        .score_right (score_right),
        .game_state  (game_state),
        .game_over   (game_over),
        .winner      (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One frame tick spanning exactly one rising edge; outputs settle by the next negedge.
    task automatic do_tick(input logic ml, input logic mr);
        @(negedge clk);
        timing_tick = 1'b1;
        miss_left   = ml;
        miss_right  = mr;
        @(negedge clk);
        timing_tick = 1'b0;
        miss_left   = 1'b0;
        miss_right  = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick(1'b0, 1'b0);
    endtask

    task automatic press_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (game_state !== S_IDLE) begin
            n_errors++; $display("FAIL reset_state: got %0d expected %0d", game_state, S_IDLE);
        end
        n_checks++;
        if ({ball_enable, game_over, winner, score_left, score_right} !== 12'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got be=%0d go=%0d w=%0d l=%0d r=%0d expected all 0",
                     ball_enable, game_over, winner, score_left, score_right);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_serve();
        press_start();
        n_checks++;
        if (game_state !== S_SERVE || ball_enable !== 1'b0) begin
            n_errors++; $display("FAIL start_to_serve: got st=%0d be=%0d expected st=1 be=0",
                                 game_state, ball_enable);
        end
        run_ticks(59);
        n_checks++;
        if (game_state !== S_SERVE || ball_enable !== 1'b0) begin
            n_errors++; $display("FAIL serve_59_ticks: got st=%0d be=%0d expected st=1 be=0",
                                 game_state, ball_enable);
        end
        run_ticks(1);
        n_checks++;
        if (game_state !== S_PLAY || ball_enable !== 1'b1) begin
            n_errors++; $display("FAIL serve_60_ticks: got st=%0d be=%0d expected st=2 be=1",
                                 game_state, ball_enable);
        end
    endtask

    task automatic test_miss_no_tick();
        @(negedge clk);
        miss_right = 1'b1;
        @(negedge clk);
        miss_right = 1'b0;
        n_checks++;
        if (game_state !== S_PLAY || score_left !== 4'd0 || score_right !== 4'd0) begin
            n_errors++; $display("FAIL miss_no_tick: got st=%0d l=%0d r=%0d expected st=2 l=0 r=0",
                                 game_state, score_left, score_right);
        end
    endtask

    task automatic test_point();
        do_tick(1'b1, 1'b0);
        n_checks++;
        if (score_right !== 4'd1 || score_left !== 4'd0 || game_state !== S_POINT ||
            ball_enable !== 1'b0) begin
            n_errors++; $display("FAIL miss_left_point: got r=%0d l=%0d st=%0d be=%0d expected 1 0 3 0",
                                 score_right, score_left, game_state, ball_enable);
        end
        run_ticks(29);
        n_checks++;
        if (game_state !== S_POINT) begin
            n_errors++; $display("FAIL point_29_ticks: got %0d expected %0d", game_state, S_POINT);
        end
        run_ticks(1);
        n_checks++;
        if (game_state !== S_SERVE) begin
            n_errors++; $display("FAIL point_30_ticks: got %0d expected %0d", game_state, S_SERVE);
        end
        // Miss during SERVE is ignored, but the tick still counts down the serve.
        do_tick(1'b0, 1'b1);
        n_checks++;
        if (game_state !== S_SERVE || score_left !== 4'd0 || score_right !== 4'd1) begin
            n_errors++; $display("FAIL miss_in_serve: got st=%0d l=%0d r=%0d expected 1 0 1",
                                 game_state, score_left, score_right);
        end
        run_ticks(58);
        n_checks++;
        if (game_state !== S_SERVE) begin
            n_errors++; $display("FAIL reserve_hold: got %0d expected %0d", game_state, S_SERVE);
        end
        run_ticks(1);
        n_checks++;
        if (game_state !== S_PLAY || ball_enable !== 1'b1) begin
            n_errors++; $display("FAIL reserve_play: got st=%0d be=%0d expected 2 1",
                                 game_state, ball_enable);
        end
    endtask

    task automatic test_double_miss();
        do_tick(1'b1, 1'b1);
        n_checks++;
        if (game_state !== S_SERVE || score_left !== 4'd0 || score_right !== 4'd1 ||
            ball_enable !== 1'b0) begin
            n_errors++; $display("FAIL double_miss: got st=%0d l=%0d r=%0d be=%0d expected 1 0 1 0",
                                 game_state, score_left, score_right, ball_enable);
        end
        run_ticks(59);
        n_checks++;
        if (game_state !== S_SERVE) begin
            n_errors++; $display("FAIL double_miss_timer: got %0d expected %0d", game_state, S_SERVE);
        end
        run_ticks(1);
        n_checks++;
        if (game_state !== S_PLAY) begin
            n_errors++; $display("FAIL double_miss_play: got %0d expected %0d", game_state, S_PLAY);
        end
    endtask

    task automatic test_game_over();
        for (int i = 0; i < 8; i++) begin
            do_tick(1'b0, 1'b1);
            run_ticks(30);
            run_ticks(60);
        end
        n_checks++;
        if (score_left !== 4'd8 || game_state !== S_PLAY) begin
            n_errors++; $display("FAIL left_at_8: got l=%0d st=%0d expected l=8 st=2",
                                 score_left, game_state);
        end
        do_tick(1'b0, 1'b1);
        n_checks++;
        if (score_left !== 4'd9 || game_over !== 1'b1 || winner !== 2'b01 ||
            game_state !== S_OVER || ball_enable !== 1'b0) begin
            n_errors++; $display("FAIL win_left: got l=%0d go=%0d w=%0d st=%0d be=%0d expected 9 1 1 4 0",
                                 score_left, game_over, winner, game_state, ball_enable);
        end
        do_tick(1'b1, 1'b0);
        run_ticks(100);
        n_checks++;
        if (score_right !== 4'd1 || score_left !== 4'd9 || winner !== 2'b01 ||
            game_state !== S_OVER) begin
            n_errors++; $display("FAIL over_hold: got l=%0d r=%0d w=%0d st=%0d expected 9 1 1 4",
                                 score_left, score_right, winner, game_state);
        end
        press_start();
        n_checks++;
        if (score_left !== 4'd0 || score_right !== 4'd0 || winner !== 2'b00 ||
            game_over !== 1'b0 || game_state !== S_SERVE) begin
            n_errors++; $display("FAIL restart: got l=%0d r=%0d w=%0d go=%0d st=%0d expected 0 0 0 0 1",
                                 score_left, score_right, winner, game_over, game_state);
        end
    endtask

    task automatic test_async_reset();
        run_ticks(60);
        do_tick(1'b1, 1'b0);
        n_checks++;
        if (game_state !== S_POINT || score_right !== 4'd1) begin
            n_errors++; $display("FAIL pre_reset_point: got st=%0d r=%0d expected 3 1",
                                 game_state, score_right);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (game_state !== S_IDLE || score_right !== 4'd0 || score_left !== 4'd0 ||
            ball_enable !== 1'b0 || game_over !== 1'b0 || winner !== 2'b00) begin
            n_errors++; $display("FAIL async_reset: got st=%0d l=%0d r=%0d be=%0d go=%0d w=%0d expected all 0",
                                 game_state, score_left, score_right, ball_enable, game_over, winner);
        end
        @(negedge clk);
        rst_n = 1'b1;
        press_start();
        n_checks++;
        if (game_state !== S_SERVE) begin
            n_errors++; $display("FAIL post_reset_start: got %0d expected %0d", game_state, S_SERVE);
        end
    endtask

    initial begin
        timing_tick = 1'b0;
        miss_left   = 1'b0;
        miss_right  = 1'b0;
        start       = 1'b0;
        rst_n       = 1'b1;
        test_reset();
        test_serve();
        test_miss_no_tick();
        test_point();
        test_double_miss();
        test_game_over();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
